tx_stream_arbiter: RTL and testbench
====================================

# tx_stream_arbiter

Packet-level round-robin arbiter that shares one 128-bit transmit stream (data/keep/last, valid/ready) among N source streams. It sits in front of the Ethernet transmit path, which consumes one packet at a time. A grant is held from the first beat to the last beat of a packet, so packets are never interleaved. The block also provides per-source packet counters and a mid-packet stall counter for debug.

## Interface
Parameters:
- N, 4, number of source streams (2..8)
- DATA_W, 128, beat width in bits
- KEEP_W, DATA_W/8, byte-enable width (derived, not overridable)

Ports:
- wClk  in  1  clock; every register updates on the rising edge
- wRst  in  1  synchronous, active-high reset
- bData_in_data_in  in  N*DATA_W  source beats; source i occupies [i*DATA_W +: DATA_W]
- bData_in_keep_in  in  N*KEEP_W  source byte enables, packed the same way
- wData_in_valid_in  in  N  per-source valid
- wData_in_last_in  in  N  per-source last-beat flag
- wData_in_ready_in  out  N  per-source ready
- bData_out_data_out  out  DATA_W  output beat
- bData_out_keep_out  out  KEEP_W  output byte enables
- wData_out_valid_out  out  1  output valid
- wData_out_last_out  out  1  output last
- wData_out_ready_out  in  1  downstream ready
- bGrant_out  out  N  one-hot current grant; all-zero when idle
- bPacket_cnt_out  out  N*32  per-source count of forwarded packets; wraps at 2^32
- bStall_cnt_out  out  32  count of cycles in BUSY with the granted source's valid low; saturates at 0xFFFFFFFF

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - If any wData_in_valid_in bit is high, select the first valid source scanning upward from rr_ptr, modulo N.
  - Register the winner into the grant. Go to BUSY on the next edge.
  - No beat is accepted in IDLE.
- BUSY:
  - wData_in_ready_in[g] = !out_valid || wData_out_ready_out. All other ready bits are 0.
  - An input beat transfers when valid[g] and ready[g] are both high. The beat is loaded into the output register.
  - When a transferred beat has last=1: the FSM returns to IDLE, rr_ptr becomes (g+1) mod N, bGrant_out clears, and bPacket_cnt[g] increments.
- Output register:
  - One entry, holding data, keep, last and valid.
  - Loads on an input transfer.
  - Clears valid on an output transfer (valid and ready) when no new beat is loaded that cycle.
  - Holds data, keep and last stable while valid=1 and ready=0.
- Non-granted sources are never stalled by protocol violations. A source may drop valid mid-packet. The grant is kept, and bStall_cnt increments each such cycle.
- Keep is passed through unmodified; no checking is done. A last beat with keep=0 is forwarded as-is.
- Reset values:
  - All outputs are 0: valid, last, data, keep, ready, grant and both counter sets.
  - rr_ptr=0 and the FSM is in IDLE.
- Reset mid-packet: the partial packet is abandoned with no last emitted. Downstream shares wRst and must flush.

## Timing
- Arbitration takes 1 cycle: valid seen in IDLE at edge k, grant visible after edge k, first beat accepted at edge k+1 at the earliest.
- Beat latency is 1 cycle: a beat accepted at edge k is on the output after edge k.
- Throughput is one beat per cycle within a packet while downstream ready=1.
- There is one idle cycle between packets (the IDLE arbitration cycle), including back-to-back packets from the same source.
- A simultaneous output drain and input load in the same cycle is allowed, with no bubble.
- Ready never depends combinationally on valid. It depends on the grant, out_valid and wData_out_ready_out only.

## Structure
- Shared package: DATA_W/KEEP_W defaults, the state encoding (IDLE=0, BUSY=1), and the counter width 32.
- Sub-module rr_pick (combinational):
  - Inputs: request vector and rr_ptr.
  - Output: one-hot winner and its index.
  - Reusable by other schedulers in the design.
- Counters and the output register live in the top level.

## Test plan
- Single 3-beat packet on src0 (data all-F, all-E, all-D; keep FFFF; last on beat 3), ready=1:
  - Grant=0001 one cycle after valid.
  - Output beats F, E, D on consecutive cycles, with last on D.
  - bPacket_cnt[0]=1; grant returns to 0000.
- All 4 sources valid with 2-beat packets, continuously re-offered after reset:
  - Grant order 0,1,2,3,0.
  - Exactly one idle cycle between packets.
  - Each counter equals 2 after 8 packets.
- wData_out_ready_out low for 3 cycles mid-packet:
  - Output data/keep/last are held constant.
  - wData_in_ready_in[g]=0 during the stall.
  - Beat sequence on the output equals the input sequence, with no loss and no duplication.
- Granted src1 drops valid for 5 cycles mid-packet while src2 is valid:
  - Grant stays 0010 and bStall_cnt=5.
  - src2 is granted only after src1's last beat transfers.
- wRst pulsed for one cycle during beat 2 of a 4-beat packet:
  - Next cycle: valid, grant and counters are 0, and no last is emitted.
  - After release with src3 and src0 valid, src0 wins (rr_ptr=0).
- src2 alone sends 10 one-beat packets (last every beat):
  - Output valid pattern 1,0 repeating.
  - bPacket_cnt[2]=10 and other counters are 0.

Source files
------------

// File: rtl/tx_stream_arbiter_pkg.sv
// Shared definitions for the transmit stream arbiter: beat width defaults,
// FSM state encoding and debug counter width.
package tx_stream_arbiter_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;
    localparam int CNT_W      = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/tx_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// scanning upward from i_ptr (wrapping modulo N), as one-hot and as an index.
module tx_stream_arbiter_rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the farthest offset back toward i_ptr so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            int cand;
            cand = (int'(i_ptr) + off) % N;
            if (i_req[cand]) begin
                o_grant       = '0;
                o_grant[cand] = 1'b1;
                o_idx         = IDX_W'(cand);
                o_valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one transmit stream among N sources.
// A grant is held from first to last beat so packets never interleave; one
// idle arbitration cycle separates packets. Includes debug counters.
module tx_stream_arbiter
    import tx_stream_arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = DATA_W_DEF,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic                wClk,
    input  logic                wRst,
    input  logic [N*DATA_W-1:0] bData_in_data_in,
    input  logic [N*KEEP_W-1:0] bData_in_keep_in,
    input  logic [N-1:0]        wData_in_valid_in,
    input  logic [N-1:0]        wData_in_last_in,
    output logic [N-1:0]        wData_in_ready_in,
    output logic [DATA_W-1:0]   bData_out_data_out,
    output logic [KEEP_W-1:0]   bData_out_keep_out,
    output logic                wData_out_valid_out,
    output logic                wData_out_last_out,
    input  logic                wData_out_ready_out,
    output logic [N-1:0]        bGrant_out,
    output logic [N*CNT_W-1:0]  bPacket_cnt_out,
    output logic [CNT_W-1:0]    bStall_cnt_out
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [N-1:0]       r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_ptr;

    logic [DATA_W-1:0]  r_out_data;
    logic [KEEP_W-1:0]  r_out_keep;
    logic               r_out_last;
    logic               r_out_valid;

    logic [CNT_W-1:0]   r_pkt_cnt [N];
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [DATA_W-1:0]  w_src_data [N];
    logic [KEEP_W-1:0]  w_src_keep [N];
    logic [N-1:0]       w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_out_free;
    logic               w_g_valid;
    logic               w_g_last;
    logic               w_xfer;
    logic               w_end;
    logic [IDX_W-1:0]   w_ptr_next;

    // Unpack the flat source buses and expose the per-source packet counters.
    for (genvar gi = 0; gi < N; gi++) begin : g_src
        assign w_src_data[gi] = bData_in_data_in[gi*DATA_W +: DATA_W];
        assign w_src_keep[gi] = bData_in_keep_in[gi*KEEP_W +: KEEP_W];
        assign bPacket_cnt_out[gi*CNT_W +: CNT_W] = r_pkt_cnt[gi];
    end

    tx_stream_arbiter_rr_pick #(.N(N)) u_rr_pick (
        .i_req   (wData_in_valid_in),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_any)
    );

    // Ready only looks at grant and output-register occupancy, never at valid.
    assign w_out_free = !r_out_valid || wData_out_ready_out;
    assign w_g_valid  = wData_in_valid_in[r_grant_idx];
    assign w_g_last   = wData_in_last_in[r_grant_idx];
    assign w_xfer     = (r_state == ST_BUSY) && w_g_valid && w_out_free;
    assign w_end      = w_xfer && w_g_last;
    assign w_ptr_next = (r_grant_idx == IDX_W'(N - 1)) ? '0 : r_grant_idx + IDX_W'(1);

    assign wData_in_ready_in   = (r_state == ST_BUSY) ? (r_grant & {N{w_out_free}}) : '0;
    assign bData_out_data_out  = r_out_data;
    assign bData_out_keep_out  = r_out_keep;
    assign wData_out_valid_out = r_out_valid;
    assign wData_out_last_out  = r_out_last;
    assign bGrant_out          = r_grant;
    assign bStall_cnt_out      = r_stall_cnt;

    // Arbitration FSM: pick a winner in IDLE, hold it until its last beat transfers.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_state     <= ST_BUSY;
                        r_grant     <= w_pick_grant;
                        r_grant_idx <= w_pick_idx;
                    end
                end
                ST_BUSY: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                    end
                end
            endcase
        end
    end

    // Single-entry output register: load on input transfer, drain on output transfer.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_data  <= w_src_data[r_grant_idx];
            r_out_keep  <= w_src_keep[r_grant_idx];
            r_out_last  <= w_g_last;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && wData_out_ready_out) begin
            r_out_valid <= 1'b0;
        end
    end

    // Per-source forwarded-packet counters, wrapping naturally.
    for (genvar gi = 0; gi < N; gi++) begin : g_cnt
        always_ff @(posedge wClk) begin
            if (wRst) begin
                r_pkt_cnt[gi] <= '0;
            end else if (w_end && (r_grant_idx == IDX_W'(gi))) begin
                r_pkt_cnt[gi] <= r_pkt_cnt[gi] + CNT_W'(1);
            end
        end
    end

    // Saturating count of BUSY cycles where the granted source withholds valid.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_BUSY) && !w_g_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed testbench for tx_stream_arbiter (N=4, 128-bit beats).
module tb_tx_stream_arbiter;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic         wClk;
    logic         wRst;
    logic [511:0] data_in;
    logic [63:0]  keep_in;
    logic [3:0]   valid_in;
    logic [3:0]   last_in;
    logic [3:0]   ready_in;
    logic [127:0] out_data;
    logic [15:0]  out_keep;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [3:0]   grant;
    logic [127:0] pkt_cnt;
    logic [31:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    beat_t       src_mem [4][16];
    int          src_rd [4];
    int          src_wr [4];
    logic [3:0]  vmask;
    beat_t       out_log [64];
    int          out_cyc [64];
    int          out_n;
    logic [3:0]  grant_log [16];
    int          grant_cyc [16];
    int          gn;
    logic [3:0]  prev_grant;
    int          cyc;

    tx_stream_arbiter #(.N(4), .DATA_W(128)) dut (
        .wClk                (wClk),
        .wRst                (wRst),
        .bData_in_data_in    (data_in),
        .bData_in_keep_in    (keep_in),
        .wData_in_valid_in   (valid_in),
        .wData_in_last_in    (last_in),
        .wData_in_ready_in   (ready_in),
        .bData_out_data_out  (out_data),
        .bData_out_keep_out  (out_keep),
        .wData_out_valid_out (out_valid),
        .wData_out_last_out  (out_last),
        .wData_out_ready_out (out_ready),
        .bGrant_out          (grant),
        .bPacket_cnt_out     (pkt_cnt),
        .bStall_cnt_out      (stall_cnt)
    );

    initial wClk = 1'b0;
    always #5 wClk = ~wClk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int s);
        return pkt_cnt[s*32 +: 32];
    endfunction

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            beat_t b;
            b = '0;
            if (src_rd[s] < src_wr[s]) b = src_mem[s][src_rd[s]];
            valid_in[s]            = (src_rd[s] < src_wr[s]) && !vmask[s];
            data_in[s*128 +: 128]  = b.d;
            keep_in[s*16 +: 16]    = b.k;
            last_in[s]             = b.l;
        end
    endtask

    task automatic push(input int s, input logic [127:0] d, input logic [15:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        src_mem[s][src_wr[s]] = b;
        src_wr[s]++;
    endtask

    task automatic clear_book();
        for (int s = 0; s < 4; s++) begin
            src_rd[s] = 0;
            src_wr[s] = 0;
        end
        vmask      = '0;
        out_n      = 0;
        gn         = 0;
        prev_grant = '0;
        cyc        = 0;
    endtask

    // One clock: sample handshakes before the edge, update source model after it.
    task automatic cycle();
        logic [3:0] fire;
        logic       ofire;
        beat_t      ob;
        #3;
        fire  = valid_in & ready_in;
        ofire = out_valid & out_ready;
        if (ofire && out_n < 64) begin
            ob = {out_data, out_keep, out_last};
            out_log[out_n] = ob;
            out_cyc[out_n] = cyc;
            out_n++;
        end
        @(posedge wClk);
        #1;
        cyc++;
        for (int s = 0; s < 4; s++) if (fire[s]) src_rd[s]++;
        drive();
        if (prev_grant == 4'b0 && grant != 4'b0 && gn < 16) begin
            grant_log[gn] = grant;
            grant_cyc[gn] = cyc;
            gn++;
        end
        prev_grant = grant;
    endtask

    task automatic do_reset();
        wRst = 1'b1;
        clear_book();
        drive();
        @(posedge wClk);
        @(posedge wClk);
        #1;
        wRst = 1'b0;
    endtask

    initial begin
        wRst      = 1'b1;
        out_ready = 1'b1;
        data_in   = '0;
        keep_in   = '0;
        valid_in  = '0;
        last_in   = '0;
        clear_book();
        @(posedge wClk);
        #1;
        do_reset();

        // ---- reset state ----
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_keep", out_keep, 0);
        chk("rst_ready", ready_in, 0);
        chk("rst_grant", grant, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_stall", stall_cnt, 0);

        // ---- single 3-beat packet on src0 ----
        push(0, {128{1'b1}}, 16'hFFFF, 1'b0);
        push(0, {32{4'hE}}, 16'hFFFF, 1'b0);
        push(0, {32{4'hD}}, 16'hFFFF, 1'b1);
        drive();
        cycle();
        chk("t1_grant", grant, 4'b0001);
        chk("t1_no_beat_in_idle", out_valid, 0);
        for (int i = 0; i < 20 && out_n < 3; i++) cycle();
        cycle(); cycle();
        chk("t1_out_n", out_n, 3);
        chk("t1_b0", out_log[0].d, {32{4'hF}});
        chk("t1_b1", out_log[1].d, {32{4'hE}});
        chk("t1_b2", out_log[2].d, {32{4'hD}});
        chk("t1_keep", out_log[2].k, 16'hFFFF);
        chk("t1_lasts", {out_log[0].l, out_log[1].l, out_log[2].l}, 3'b001);
        chk("t1_consecutive", out_cyc[2] - out_cyc[0], 2);
        chk("t1_cnt0", cnt(0), 1);
        chk("t1_grant_clear", grant, 0);

        // ---- all four sources, 2 packets x 2 beats each ----
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 4; s++)
                for (int bb = 0; bb < 2; bb++)
                    push(s, 128'(s * 65536 + p * 256 + bb), 16'h00FF, bb == 1);
        drive();
        for (int i = 0; i < 100 && out_n < 16; i++) cycle();
        chk("t2_out_n", out_n, 16);
        chk("t2_gn", gn, 8);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t2_grant_%0d", i), grant_log[i], 4'b0001 << (i % 4));
        for (int i = 0; i < 7; i++)
            chk($sformatf("t2_gap_%0d", i), grant_cyc[i+1] - grant_cyc[i], 3);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t2_beat_%0d", i), out_log[i].d, 128'(((i / 2) % 4) * 65536 + (i / 8) * 256 + (i % 2)));
        for (int s = 0; s < 4; s++)
            chk($sformatf("t2_cnt%0d", s), cnt(s), 2);
        chk("t2_stall", stall_cnt, 0);

        // ---- downstream stall mid-packet on src1 ----
        do_reset();
        for (int bb = 0; bb < 4; bb++) push(1, 128'(32'hA000 + bb), 16'h0F0F, bb == 3);
        drive();
        cycle(); cycle(); cycle();
        chk("t3_pre_data", out_data, 128'(32'hA001));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("t3_hold_data_%0d", i), out_data, 128'(32'hA001));
            chk($sformatf("t3_hold_kl_%0d", i), {out_valid, out_keep, out_last}, {1'b1, 16'h0F0F, 1'b0});
            chk($sformatf("t3_ready_%0d", i), ready_in, 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_n < 4; i++) cycle();
        cycle(); cycle();
        chk("t3_out_n", out_n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_seq_%0d", i), {out_log[i].d, out_log[i].l}, {128'(32'hA000 + i), i == 3});
        chk("t3_stall", stall_cnt, 0);

        // ---- granted src1 drops valid for 5 cycles while src2 waits ----
        do_reset();
        for (int bb = 0; bb < 3; bb++) push(1, 128'(32'hB100 + bb), 16'hFFFF, bb == 2);
        push(2, 128'(32'hB200), 16'hFFFF, 1'b1);
        drive();
        cycle();
        chk("t4_grant", grant, 4'b0010);
        cycle();
        vmask = 4'b0010;
        drive();
        for (int i = 0; i < 5; i++) cycle();
        chk("t4_grant_held", grant, 4'b0010);
        chk("t4_stall", stall_cnt, 5);
        vmask = '0;
        drive();
        for (int i = 0; i < 20 && out_n < 4; i++) cycle();
        cycle();
        chk("t4_out_n", out_n, 4);
        chk("t4_gn", gn, 2);
        chk("t4_grant2", grant_log[1], 4'b0100);
        chk("t4_order", out_log[3].d, 128'(32'hB200));
        chk("t4_src1_last", out_log[2].d, 128'(32'hB102));
        chk("t4_stall_end", stall_cnt, 5);

        // ---- reset during beat 2 of a 4-beat packet ----
        do_reset();
        push(1, 128'(32'hC100), 16'hFFFF, 1'b1);
        for (int bb = 0; bb < 4; bb++) push(2, 128'(32'hC200 + bb), 16'hFFFF, bb == 3);
        drive();
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_grant_pre", grant, 4'b0100);
        chk("t5_beat2_on_out", out_data, 128'(32'hC201));
        chk("t5_cnt1_pre", cnt(1), 1);
        wRst = 1'b1;
        @(posedge wClk);
        #1;
        wRst = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_last", out_last, 0);
        chk("t5_grant", grant, 0);
        chk("t5_cnts", pkt_cnt, 0);
        chk("t5_out_n", out_n, 2);
        clear_book();
        push(3, 128'(32'hC300), 16'hFFFF, 1'b1);
        push(0, 128'(32'hC000), 16'hFFFF, 1'b1);
        drive();
        cycle();
        chk("t5_ptr_reset_src0", grant, 4'b0001);

        // ---- src2 sends ten one-beat packets ----
        do_reset();
        for (int p = 0; p < 10; p++) push(2, 128'(32'hD000 + p), 16'h0001, 1'b1);
        drive();
        begin
            logic [19:0] vpat;
            vpat = '0;
            for (int i = 0; i < 20; i++) begin
                cycle();
                vpat[i] = out_valid;
            end
            chk("t6_valid_pattern", vpat, 20'hAAAAA);
        end
        chk("t6_cnt2", cnt(2), 10);
        chk("t6_cnt_others", {cnt(0), cnt(1), cnt(3)}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
